// File: rtl/sram_arbiter.sv
// sram_arbiter: grants one write port and one read port access to an asynchronous SRAM.
// Build option SRAM_ARB_RR_EN: round-robin on simultaneous requests (default: write priority).
module sram_arbiter #(
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [16:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [16:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [2:0]  state,
  output logic [16:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  // Handshake: a requester raises req with addr (and data) and holds all of them stable
  // until its single-cycle wr_ack / rd_valid pulse; a pending request is never dropped.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    HOLD  = 3'd2,
    READ  = 3'd3,
    TURN  = 3'd4
  } state_t;

  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [16:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rd_data;
  logic        r_drive;
  logic        r_armed;
  logic        r_busy;
  logic        r_wr_ack;
  logic        r_rd_valid;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        w_pick_wr;

`ifdef SRAM_ARB_RR_EN
  logic r_last_rd;
  // Contention goes to the port that did not win the previous grant.
  assign w_pick_wr = wr_req && (!rd_req || r_last_rd);
`else
  assign w_pick_wr = wr_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 17'd0;
      r_wdata    <= 8'd0;
      r_rd_data  <= 8'd0;
      r_drive    <= 1'b0;
      r_armed    <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
`ifdef SRAM_ARB_RR_EN
      r_last_rd  <= 1'b1;
`endif
    end else begin
      // r_armed blocks a grant on the first edge after reset release.
      r_armed    <= 1'b1;
      r_wr_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_armed && (wr_req || rd_req)) begin
            r_busy <= 1'b1;
            r_ce_n <= 1'b0;
            if (w_pick_wr) begin
              r_state <= WRITE;
              r_addr  <= wr_addr;
              r_wdata <= wr_data;
              r_we_n  <= 1'b0;
              r_drive <= 1'b1;
              r_cnt   <= WR_LOAD;
`ifdef SRAM_ARB_RR_EN
              r_last_rd <= 1'b0;
`endif
            end else begin
              r_state <= READ;
              r_addr  <= rd_addr;
              r_oe_n  <= 1'b0;
              r_cnt   <= RD_LOAD;
`ifdef SRAM_ARB_RR_EN
              r_last_rd <= 1'b1;
`endif
            end
          end
        end
        WRITE: begin
          if (r_cnt == 4'd0) begin
            r_state  <= HOLD;
            r_we_n   <= 1'b1;
            r_ce_n   <= 1'b1;
            r_wr_ack <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          // Data stays on the bus one cycle past the we_n rise for hold time.
          r_state <= IDLE;
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
        end
        READ: begin
          if (r_cnt == 4'd0) begin
            r_state    <= TURN;
            r_rd_data  <= sram_data;
            r_oe_n     <= 1'b1;
            r_ce_n     <= 1'b1;
            r_rd_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        TURN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sram_data = r_drive ? r_wdata : 8'bz;
  assign sram_addr = r_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign wr_ack    = r_wr_ack;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign state     = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed access/reset scenarios plus random
// traffic against a byte-array reference memory and an expected read-data queue.
module tb_sram_arbiter;
  localparam int WR_CYCLES = 2;
  localparam int RD_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic [2:0]  state;
  logic [16:0] sram_addr;
  wire  [7:0]  sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  sram_arbiter #(.WR_CYCLES(WR_CYCLES), .RD_CYCLES(RD_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .state(state),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- asynchronous SRAM model ----------------
  logic [7:0] sram_mem [0:131071];
  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 8'bz;
  always @(negedge clk) if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_data;

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ref_mem [int];
  int          wr_addrs[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  grant_q[$];
  int          grant_cyc_q[$];
  logic [7:0]  exp_g[$];
  logic [16:0] st_addr[$];
  logic [7:0]  st_data[$];
  logic [7:0]  last_rd_val = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant log (type and cycle) and bus-safety watch, sampled on the falling edge.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      grant_q.push_back(sram_we_n ? "R" : "W");
      grant_cyc_q.push_back(cyc);
    end
    prev_busy = busy;
    if (!sram_oe_n || !sram_we_n) chk("oe_we_exclusive", {31'd0, sram_oe_n | sram_we_n}, 32'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input string tag);
    bit g = 1'b0;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk);
      g = busy;
    end
    chk(tag, g, 1);
  endtask

  task automatic do_write(input logic [16:0] a, input logic [7:0] d, input bit already_req);
    int lat = 1;
    int n_we = 0;
    bit done = 1'b0;
    if (!already_req) begin
      @(negedge clk);
      wr_addr = a; wr_data = d; wr_req = 1'b1;
    end
    wait_grant("wr_grant");
    // Cycle 1 is the cycle that follows the grant edge.
    for (int i = 0; i < 40 && !done; i++) begin
      if (wr_ack) begin
        done = 1'b1;
        chk("wr_hold_data", sram_data, d);
        chk("wr_hold_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      end else begin
        if (!sram_we_n) begin
          n_we++;
          chk("wr_addr_pin", sram_addr, a);
        end
        @(negedge clk);
        lat++;
      end
    end
    chk("wr_ack_seen", done, 1);
    chk("wr_latency", lat, WR_CYCLES + 1);
    chk("wr_we_cycles", n_we, WR_CYCLES);
    wr_req = 1'b0;
    ref_mem[a] = d;
    wr_addrs.push_back(a);
    @(negedge clk);
    chk("wr_idle_busy", busy, 0);
    chk("wr_addr_retained", sram_addr, a);
    chk("rd_data_hold", rd_data, last_rd_val);
  endtask

  task automatic do_read(input logic [16:0] a);
    int lat = 1;
    int n_oe = 0;
    bit done = 1'b0;
    logic [7:0] e;
    exp_q.push_back(ref_mem[a]);
    @(negedge clk);
    rd_addr = a; rd_req = 1'b1;
    wait_grant("rd_grant");
    for (int i = 0; i < 40 && !done; i++) begin
      if (rd_valid) begin
        done = 1'b1;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
        last_rd_val = e;
        chk("rd_turn_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      end else begin
        if (!sram_oe_n) begin
          n_oe++;
          chk("rd_addr_pin", sram_addr, a);
        end
        @(negedge clk);
        lat++;
      end
    end
    if (!done) exp_q.delete();
    chk("rd_valid_seen", done, 1);
    chk("rd_latency", lat, RD_CYCLES + 1);
    chk("rd_oe_cycles", n_oe, RD_CYCLES);
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_idle_busy", busy, 0);
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_data_held", rd_data, last_rd_val);
  endtask

  // Write stream from st_addr/st_data with one read (rd_addr) pending alongside it.
  task automatic serve_stream();
    @(negedge clk);
    wr_addr = st_addr[0]; wr_data = st_data[0];
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 300 && (wr_req || rd_req); i++) begin
      @(negedge clk);
      if (wr_ack) begin
        ref_mem[wr_addr] = wr_data;
        wr_addrs.push_back(wr_addr);
        void'(st_addr.pop_front());
        void'(st_data.pop_front());
        if (st_addr.size() > 0) begin
          wr_addr = st_addr[0]; wr_data = st_data[0];
        end else begin
          wr_req = 1'b0;
        end
      end
      if (rd_valid) begin
        if (exp_q.size() > 0) last_rd_val = exp_q.pop_front();
        chk("stream_rd_data", rd_data, last_rd_val);
        rd_req = 1'b0;
      end
    end
    chk("stream_done", {wr_req, rd_req}, 2'b00);
    wr_req = 1'b0; rd_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_count"}, grant_q.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < grant_q.size(); i++)
      chk(tag, grant_q[i], exp_g[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [16:0] a;
    logic [7:0]  d;
    foreach (sram_mem[i]) sram_mem[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single write then read-back of the same location
    do_write(17'h00010, 8'hA5, 1'b0);
    chk("sram_cell_10", sram_mem[17'h00010], 8'hA5);
    do_read(17'h00010);

    // Simultaneous requests: write wins in both policies, read follows HOLD
    grant_q.delete(); grant_cyc_q.delete();
    st_addr = '{17'h00040}; st_data = '{8'h5A};
    rd_addr = 17'h00040;
    exp_q.push_back(8'h5A);
    serve_stream();
    exp_g = '{"W", "R"};
    check_order("simul_order");
    if (grant_cyc_q.size() >= 2)
      chk("write_period", grant_cyc_q[1] - grant_cyc_q[0], WR_CYCLES + 2);

    // Continuous write stream with a read pending
    grant_q.delete(); grant_cyc_q.delete();
    st_addr = '{17'h00100, 17'h00101, 17'h00102, 17'h00103};
    st_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_addr = 17'h00010;
    exp_q.push_back(ref_mem[17'h00010]);
    serve_stream();
`ifdef SRAM_ARB_RR_EN
    exp_g = '{"W", "R", "W", "W", "W"};
`else
    exp_g = '{"W", "W", "W", "W", "R"};
`endif
    check_order("stream_order");
    if (grant_cyc_q.size() >= 2)
      chk("stream_period", grant_cyc_q[1] - grant_cyc_q[0], WR_CYCLES + 2);
    do_read(17'h00102);

    // Reset in the second WRITE cycle abandons the access
    @(negedge clk);
    wr_addr = 17'h00020; wr_data = 8'h77; wr_req = 1'b1;
    wait_grant("abort_grant");
    @(negedge clk);
    chk("abort_we_low", sram_we_n, 0);
    rst = 1'b0;
    #1;
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("abort_busy", busy, 0);
    chk("abort_state", state, 0);
    chk("abort_addr", sram_addr, 0);
    wr_req = 1'b0;
    last_rd_val = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", wr_ack, 0);
    end
    wr_addr = 17'h1FFFF; wr_data = 8'h3C; wr_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("first_edge_no_grant", busy, 0);
    do_write(17'h1FFFF, 8'h3C, 1'b1);
    do_read(17'h1FFFF);

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      if (wr_addrs.size() == 0 || $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       a = 17'h00000;
          1:       a = 17'h1FFFF;
          default: a = 17'($urandom_range(0, 17'h1FFFF));
        endcase
        d = 8'($urandom);
        do_write(a, d, 1'b0);
      end else begin
        do_read(17'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]));
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter WR_CYCLES, default 2: clk cycles sram_we_n is held low per write (legal range 1..15).
REQ-002 The block SHALL have parameter RD_CYCLES, default 2: clk cycles sram_oe_n is held low before data capture (legal range 1..15).
REQ-003 The block SHALL have port clk  in  1  system clock (100 MHz); the block uses one clock only.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports wr_req in 1, wr_addr in 17, wr_data in 8, wr_ack out 1: capture write port.
REQ-006 The block SHALL have ports rd_req in 1, rd_addr in 17, rd_data out 8, rd_valid out 1: readout read port.
REQ-007 The block SHALL have port busy  out  1  high in every state other than IDLE.
REQ-008 The block SHALL have ports sram_addr out 17, sram_data inout 8, sram_ce_n out 1, sram_oe_n out 1, sram_we_n out 1: asynchronous SRAM.

Function
REQ-009 The FSM SHALL have states IDLE, WRITE, HOLD, READ and TURN; grant decisions SHALL be made only in IDLE.
REQ-010 On a grant, the block SHALL latch the address (and data for writes) on the grant edge; requesters SHALL hold req, addr and data stable until wr_ack or rd_valid.
REQ-011 In WRITE, the block SHALL assert sram_ce_n=0 and sram_we_n=0, keep sram_oe_n=1 and drive sram_data for exactly WR_CYCLES cycles.
REQ-012 In HOLD (1 cycle), the block SHALL set sram_we_n=1 and sram_ce_n=1, keep driving sram_data, pulse wr_ack for 1 cycle, then go to IDLE.
REQ-013 In READ, the block SHALL assert sram_ce_n=0 and sram_oe_n=0 with sram_data tri-stated for RD_CYCLES cycles, and register sram_data into rd_data on the final READ edge.
REQ-014 In TURN (1 cycle), the block SHALL set sram_oe_n=1 and sram_ce_n=1 with sram_data tri-stated, pulse rd_valid for 1 cycle, then go to IDLE.
REQ-015 rd_data SHALL hold its value until the next read completes.
REQ-016 Latency from grant edge SHALL be WR_CYCLES+1 cycles to wr_ack and RD_CYCLES+1 cycles to rd_valid.
REQ-017 The back-to-back access period SHALL be WR_CYCLES+2 cycles per write and RD_CYCLES+2 cycles per read.
REQ-018 sram_data SHALL be driven only in WRITE and HOLD, never in READ, TURN or IDLE.
REQ-019 sram_addr SHALL be stable from grant until leaving HOLD/TURN, and SHALL retain its last value in IDLE.
REQ-020 The full address range 0x00000..0x1FFFF SHALL pass through unmodified; the block SHALL perform no wrap or bound logic.
REQ-021 A rd_req arriving during a write (or wr_req during a read) SHALL wait for IDLE; no request SHALL be dropped.
REQ-022 All SRAM strobes and wr_ack, rd_valid and busy SHALL be register outputs, with no combinational path from req inputs.

Reset
REQ-023 While rst=0, outputs SHALL be: sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0, sram_data=Z, wr_ack=0, rd_valid=0, rd_data=0, busy=0, state=IDLE.
REQ-024 Reset assertion mid-access SHALL release strobes and the bus immediately (asynchronously); the in-flight access SHALL be abandoned with no ack or valid.
REQ-025 After rst deasserts, the first grant SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-026 With macro SRAM_ARB_RR_EN defined, simultaneous pending requests in IDLE SHALL be granted round-robin (the port not granted last wins); the last-grant register SHALL reset to "read", so a write wins first.
REQ-027 Without SRAM_ARB_RR_EN, wr_req SHALL have strict priority over rd_req, and a continuous write stream MAY starve reads.

Verification
REQ-028 Write 0x00010/0xA5, WR_CYCLES=2 -> sram_we_n low exactly 2 cycles, wr_ack pulse 3 cycles after grant, data driven through HOLD.
REQ-029 Read 0x00010 against an SRAM model holding 0xA5, RD_CYCLES=2 -> sram_oe_n low 2 cycles, rd_valid 3 cycles after grant, rd_data=0xA5.
REQ-030 wr_req and rd_req raised in the same cycle -> write first, then read; HOLD precedes READ with no cycle where both bus drivers are active.
REQ-031 Continuous wr_req with rd_req pending: with SRAM_ARB_RR_EN -> read granted after 1 write; without -> no read until wr_req drops.
REQ-032 rst=0 at 2nd WRITE cycle -> sram_we_n/sram_ce_n=1 and sram_data=Z within the same cycle, no wr_ack; after release, new write to 0x1FFFF/0x3C succeeds and reads back 0x3C.
